// File: rtl/rv_multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per
// instruction and drives every datapath enable.
//
// Memory handshake: a request (imem_req / dmem_req) is held high for as long as
// the FSM sits in FETCH / MEM. A cycle with req=1 and ready=1 completes the
// access; a cycle with req=1 and ready=0 is a stall cycle. After MEM_WAIT_MAX
// consecutive stall cycles the FSM traps with mem_timeout set. A ready in the
// cycle that would otherwise be the last allowed stall completes normally.
module rv_multicycle_controller #(
  parameter int ALU_SEL_W    = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 BrEq,
  input  logic                 BrLT,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 IRWEn,
  output logic                 PCWEn,
  output logic                 PCSel,
  output logic [2:0]           ImmSel,
  output logic                 RegWEn,
  output logic                 Asel,
  output logic                 Bsel,
  output logic                 BrUn,
  output logic [ALU_SEL_W-1:0] ALUSel,
  output logic [1:0]           WBSel,
  output logic                 illegal,
  output logic                 mem_timeout,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  // Stall count at which one more stalled cycle reaches the limit.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;

  logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic is_jump, use_pc, legal, br_taken;
  logic [2:0]           imm_sel;
  logic [ALU_SEL_W-1:0] alu_code;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jump  = is_jal | is_jalr;
  assign use_pc   = is_br | is_jal | is_auipc;
  assign legal    = (is_r | is_i | is_load | is_store | is_jump | is_lui | is_auipc |
                     (is_br & (funct3[2:1] != 2'b01)));

  // Immediate format and ALU operation decoded from the latched IR fields.
  always_comb begin
    imm_sel  = 3'b000;
    alu_code = '0;
    if (is_store)                imm_sel = 3'b001;
    else if (is_br)              imm_sel = 3'b010;
    else if (is_lui | is_auipc)  imm_sel = 3'b011;
    else if (is_jal)             imm_sel = 3'b100;
    if (is_r)        alu_code[3:0] = {funct7_5, funct3};
    else if (is_i)   alu_code[3:0] = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
    else if (is_lui) alu_code = '1;
  end

  // Branch condition: funct3[2] picks less-than vs equal, funct3[0] inverts.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = BrEq;
      3'b001: br_taken = ~BrEq;
      3'b100, 3'b110: br_taken = BrLT;
      3'b101, 3'b111: br_taken = ~BrLT;
      default: br_taken = 1'b0;
    endcase
  end

  // State register, stall counter and sticky trap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and datapath control; everything forced low while rst is high.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    IRWEn     = 1'b0;
    PCWEn     = 1'b0;
    PCSel     = 1'b0;
    ImmSel    = 3'b000;
    RegWEn    = 1'b0;
    Asel      = 1'b0;
    Bsel      = 1'b0;
    BrUn      = 1'b0;
    ALUSel    = '0;
    WBSel     = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWEn   = 1'b1;
          PCWEn   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        ImmSel = imm_sel;
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUSel = alu_code;
        Asel   = use_pc;
        Bsel   = ~is_r;
        if (is_br) begin
          BrUn    = (funct3[2:1] == 2'b11);
          PCWEn   = br_taken;
          PCSel   = br_taken;
          state_d = S_FETCH;
        end else if (is_load | is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        ALUSel   = alu_code;
        Bsel     = 1'b1;
        if (dmem_ready) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        RegWEn  = 1'b1;
        WBSel   = is_load ? 2'b00 : (is_jump ? 2'b10 : 2'b01);
        state_d = S_FETCH;
        if (is_jump) begin
          PCWEn  = 1'b1;
          PCSel  = 1'b1;
          ALUSel = alu_code;
          Asel   = use_pc;
          Bsel   = 1'b1;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      IRWEn    = 1'b0;
      PCWEn    = 1'b0;
      PCSel    = 1'b0;
      ImmSel   = 3'b000;
      RegWEn   = 1'b0;
      Asel     = 1'b0;
      Bsel     = 1'b0;
      BrUn     = 1'b0;
      ALUSel   = '0;
      WBSel    = 2'b00;
    end
  end

  assign state       = rst ? 3'b000 : state_q;
  assign illegal     = illegal_q & ~rst;
  assign mem_timeout = timeout_q & ~rst;

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Bench for rv_multicycle_controller: a trace model expands each instruction
// into its expected per-cycle control vectors, the bench replays the matching
// input schedule and compares every cycle.
module tb_rv_multicycle_controller;

  localparam int MAXW = 15;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_BAD = 9;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       irwen;
    logic       pcwen;
    logic       pcsel;
    logic [2:0] immsel;
    logic       regwen;
    logic       asel;
    logic       bsel;
    logic       brun;
    logic [3:0] alusel;
    logic [1:0] wbsel;
    logic       ill;
    logic       tmo;
  } obs_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       imem_ready;
    logic       dmem_ready;
    logic       breq;
    logic       brlt;
  } drv_t;

  logic clk, rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7_5, BrEq, BrLT, imem_ready, dmem_ready;
  logic imem_req, dmem_req, dmem_we, IRWEn, PCWEn, PCSel, RegWEn, Asel, Bsel, BrUn;
  logic [2:0] ImmSel, state;
  logic [3:0] ALUSel;
  logic [1:0] WBSel;
  logic illegal, mem_timeout;

  obs_t exp_q[$];
  drv_t drv_q[$];
  int   n_tests, n_fail;
  logic m_ill, m_tmo;

  rv_multicycle_controller #(.ALU_SEL_W(4), .MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .BrEq(BrEq), .BrLT(BrLT), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .IRWEn(IRWEn),
    .PCWEn(PCWEn), .PCSel(PCSel), .ImmSel(ImmSel), .RegWEn(RegWEn), .Asel(Asel),
    .Bsel(Bsel), .BrUn(BrUn), .ALUSel(ALUSel), .WBSel(WBSel), .illegal(illegal),
    .mem_timeout(mem_timeout), .state(state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.imem_req = imem_req; o.dmem_req = dmem_req; o.dmem_we = dmem_we;
    o.irwen = IRWEn; o.pcwen = PCWEn; o.pcsel = PCSel; o.immsel = ImmSel;
    o.regwen = RegWEn; o.asel = Asel; o.bsel = Bsel; o.brun = BrUn;
    o.alusel = ALUSel; o.wbsel = WBSel; o.ill = illegal; o.tmo = mem_timeout;
    return o;
  endfunction

  function automatic int cls(input logic [6:0] op);
    case (op)
      7'h33: return C_R;
      7'h13: return C_I;
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h63: return C_BR;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      default: return C_BAD;
    endcase
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st; e.ill = m_ill; e.tmo = m_tmo;
    return e;
  endfunction

  function automatic drv_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic breq, input logic brlt);
    drv_t d;
    d.op = op; d.f3 = f3; d.f7 = f7; d.breq = breq; d.brlt = brlt;
    d.imem_ready = 1'($urandom_range(0, 1));
    d.dmem_ready = 1'($urandom_range(0, 1));
    return d;
  endfunction

  task automatic push(input obs_t e, input drv_t d);
    exp_q.push_back(e);
    drv_q.push_back(d);
  endtask

  task automatic push_trap(input int k, input drv_t d0);
    drv_t d;
    for (int i = 0; i < k; i++) begin
      d = mk(d0.op, d0.f3, d0.f7, d0.breq, d0.brlt);
      push(base(3'd5), d);
    end
  endtask

  // Reference model: expand one instruction into its cycle-by-cycle expectation.
  task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic breq, input logic brlt,
                           input int fstall, input int mstall);
    obs_t e;
    drv_t d;
    int   c;
    logic taken;
    c = cls(op);
    // Fetch with stalls.
    for (int i = 0; i < ((fstall < MAXW) ? fstall : MAXW); i++) begin
      e = base(3'd0); e.imem_req = 1'b1;
      d = mk(op, f3, f7, breq, brlt); d.imem_ready = 1'b0;
      push(e, d);
    end
    if (fstall >= MAXW) begin
      m_tmo = 1'b1;
      push_trap(3, d);
      return;
    end
    e = base(3'd0); e.imem_req = 1'b1; e.irwen = 1'b1; e.pcwen = 1'b1;
    d = mk(op, f3, f7, breq, brlt); d.imem_ready = 1'b1;
    push(e, d);
    // Decode.
    e = base(3'd1);
    case (c)
      C_ST:           e.immsel = 3'b001;
      C_BR:           e.immsel = 3'b010;
      C_LUI, C_AUIPC: e.immsel = 3'b011;
      C_JAL:          e.immsel = 3'b100;
      default:        e.immsel = 3'b000;
    endcase
    d = mk(op, f3, f7, breq, brlt);
    push(e, d);
    if (c == C_BAD || (c == C_BR && (f3 == 3'b010 || f3 == 3'b011))) begin
      m_ill = 1'b1;
      push_trap(3, d);
      return;
    end
    // Execute.
    e = base(3'd2);
    case (c)
      C_R:     e.alusel = {f7, f3};
      C_I:     e.alusel = {(f3 == 3'd5) ? f7 : 1'b0, f3};
      C_LUI:   e.alusel = 4'hF;
      default: e.alusel = 4'h0;
    endcase
    e.asel = (c == C_BR || c == C_JAL || c == C_AUIPC);
    e.bsel = (c != C_R);
    if (c == C_BR) begin
      e.brun  = (f3 == 3'd6 || f3 == 3'd7);
      taken   = (f3[2] ? brlt : breq) ^ f3[0];
      e.pcwen = taken;
      e.pcsel = taken;
    end
    push(e, mk(op, f3, f7, breq, brlt));
    if (c == C_BR) return;
    // Memory access.
    if (c == C_LD || c == C_ST) begin
      for (int i = 0; i < ((mstall < MAXW) ? mstall : MAXW); i++) begin
        e = base(3'd3); e.dmem_req = 1'b1; e.dmem_we = (c == C_ST); e.bsel = 1'b1;
        d = mk(op, f3, f7, breq, brlt); d.dmem_ready = 1'b0;
        push(e, d);
      end
      if (mstall >= MAXW) begin
        m_tmo = 1'b1;
        push_trap(3, d);
        return;
      end
      e = base(3'd3); e.dmem_req = 1'b1; e.dmem_we = (c == C_ST); e.bsel = 1'b1;
      d = mk(op, f3, f7, breq, brlt); d.dmem_ready = 1'b1;
      push(e, d);
      if (c == C_ST) return;
    end
    // Write back.
    e = base(3'd4); e.regwen = 1'b1;
    e.wbsel = (c == C_LD) ? 2'b00 : ((c == C_JAL || c == C_JALR) ? 2'b10 : 2'b01);
    if (c == C_JAL || c == C_JALR) begin
      e.pcwen = 1'b1; e.pcsel = 1'b1; e.bsel = 1'b1; e.asel = (c == C_JAL);
    end
    push(e, mk(op, f3, f7, breq, brlt));
  endtask

  // Replay queued cycles (at most max_cyc), comparing each one.
  task automatic run_trace(input string name, input int max_cyc);
    obs_t e, o;
    drv_t d;
    int   k;
    k = 0;
    while (exp_q.size() > 0 && k < max_cyc) begin
      e = exp_q.pop_front();
      d = drv_q.pop_front();
      opcode = d.op; funct3 = d.f3; funct7_5 = d.f7;
      imem_ready = d.imem_ready; dmem_ready = d.dmem_ready; BrEq = d.breq; BrLT = d.brlt;
      #1;
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h (state %0d vs %0d)",
                 name, k, o, e, o.st, e.st);
      end
      k++;
      @(posedge clk); #1;
    end
    exp_q.delete();
    drv_q.delete();
  endtask

  task automatic do_reset();
    obs_t o;
    rst = 1'b1;
    opcode = 7'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
    imem_ready = 1'b1; dmem_ready = 1'b1; BrEq = 1'($urandom); BrLT = 1'($urandom);
    #1;
    o = observe();
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL rst_high_outputs: got %h expected 0", o);
    end
    @(posedge clk); #1;
    o = observe();
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL rst_after_edge_outputs: got %h expected 0", o);
    end
    rst = 1'b0;
    m_ill = 1'b0;
    m_tmo = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    add_instr(7'h33, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("add", 1000);
  endtask

  task automatic test_alu_codes();
    add_instr(7'h33, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_trace("sub", 1000);
    add_instr(7'h13, 3'b101, 1'b1, 1'b0, 1'b0, 0, 0);
    run_trace("srai", 1000);
    add_instr(7'h13, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_trace("addi_f7", 1000);
    add_instr(7'h37, 3'b010, 1'b1, 1'b0, 1'b0, 1, 0);
    run_trace("lui", 1000);
    add_instr(7'h17, 3'b110, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("auipc", 1000);
  endtask

  task automatic test_branch();
    add_instr(7'h63, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("bgeu_taken", 1000);
    add_instr(7'h63, 3'b111, 1'b0, 1'b0, 1'b1, 0, 0);
    run_trace("bgeu_not_taken", 1000);
    for (int i = 0; i < 8; i++) begin
      add_instr(7'h63, (i[0] ? 3'b000 : 3'b001) | (i[1] ? 3'b100 : 3'b000) | (i[2] ? 3'b010 : 3'b000),
                1'b0, 1'($urandom), 1'($urandom), 0, 0);
      run_trace("branch_mix", 1000);
      if (m_ill) do_reset();
    end
  endtask

  task automatic test_load_store();
    add_instr(7'h03, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
    run_trace("lw_stall3", 1000);
    add_instr(7'h23, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("sw", 1000);
    add_instr(7'h23, 3'b000, 1'b0, 1'b0, 1'b0, 2, MAXW - 1);
    run_trace("sw_stall_max_minus_1", 1000);
  endtask

  task automatic test_timeout();
    add_instr(7'h33, 3'b000, 1'b0, 1'b0, 1'b0, MAXW - 1, 0);
    run_trace("fetch_stall_max_minus_1", 1000);
    add_instr(7'h33, 3'b000, 1'b0, 1'b0, 1'b0, MAXW, 0);
    run_trace("fetch_timeout", 1000);
    do_reset();
    add_instr(7'h03, 3'b000, 1'b0, 1'b0, 1'b0, 0, MAXW);
    run_trace("dmem_timeout", 1000);
    do_reset();
    add_instr(7'h13, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("after_timeout_reset", 1000);
  endtask

  task automatic test_illegal();
    add_instr(7'h7F, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("illegal_opcode", 1000);
    do_reset();
    add_instr(7'h63, 3'b011, 1'b0, 1'b1, 1'b1, 0, 0);
    run_trace("illegal_branch_f3", 1000);
    do_reset();
  endtask

  task automatic test_jump();
    add_instr(7'h6F, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("jal", 1000);
    add_instr(7'h67, 3'b000, 1'b1, 1'b0, 1'b0, 2, 0);
    run_trace("jalr", 1000);
  endtask

  task automatic test_mid_reset();
    obs_t e, o;
    add_instr(7'h6F, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_trace("jal_partial", 3);
    do_reset();
    opcode = 7'h6F; imem_ready = 1'b0;
    #1;
    o = observe();
    e = '0; e.st = 3'd0; e.imem_req = 1'b1;
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL mid_reset_fetch: got %h expected %h", o, e);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[9];
    logic [6:0] op;
    logic [2:0] f3;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      f3 = 3'($urandom);
      if (op == 7'h63 && f3[2:1] == 2'b01) f3[1] = 1'b0;
      add_instr(op, f3, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_trace("random_stream", 100000);
  endtask

  // Test sequence and summary.
  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ill   = 1'b0;
    m_tmo   = 1'b0;
    rst = 1'b1;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0; BrEq = 1'b0; BrLT = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_add();
    test_alu_codes();
    test_branch();
    test_load_store();
    test_timeout();
    test_illegal();
    test_jump();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_controller.md
Name: rv_multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I core; the generalised successor to the single-cycle combinational controller.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives all datapath enables.
- Covers full RV32I control classes: R, I-ALU, load, store, branch (incl. unsigned), JAL, JALR, LUI, AUIPC.
- Handshakes with instruction and data memories that may stall, with a wait-timeout trap.

Parameters:
ALU_SEL_W, 4, ALUSel width; code = {funct7_5, funct3}; must be >= 4
MEM_WAIT_MAX, 15, max consecutive stalled cycles on imem/dmem before trap (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
BrEq  in  1  branch comparator equal
BrLT  in  1  branch comparator less-than (signedness per BrUn)
imem_ready  in  1  instruction memory ready
dmem_ready  in  1  data memory ready
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  data write enable (store)
IRWEn  out  1  latch IR and OldPC
PCWEn  out  1  PC write enable
PCSel  out  1  0: PC+4, 1: ALU result
ImmSel  out  3  000 I, 001 S, 010 B, 011 U, 100 J
RegWEn  out  1  register file write
Asel  out  1  0: rs1, 1: OldPC
Bsel  out  1  0: rs2, 1: imm
BrUn  out  1  unsigned compare
ALUSel  out  ALU_SEL_W  ALU op
WBSel  out  2  00 mem, 01 ALU, 10 PC+4 (OldPC+4)
illegal  out  1  sticky: illegal opcode/funct3 trapped
mem_timeout  out  1  sticky: memory wait exceeded
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5

Behaviour:
- Reset: state = FETCH; wait counter = 0; illegal = mem_timeout = 0. All outputs 0 while rst is high.
- Outputs are decoded from the state and the latched IR fields. Any output not listed for a state is 0.
- FETCH:
  - imem_req = 1.
  - On imem_ready: IRWEn = 1, PCWEn = 1, PCSel = 0; go to DECODE. imem_req falls in the next cycle.
  - Otherwise the counter increments. When the counter reaches MEM_WAIT_MAX: mem_timeout = 1, go to TRAP.
- DECODE:
  - ImmSel per class.
  - Unknown opcode, or branch funct3 010/011: illegal = 1, go to TRAP. Otherwise go to EXEC.
- EXEC, ALUSel:
  - R-type: {funct7_5, funct3}.
  - I-ALU: {funct7_5 only when funct3 = 101, else 0, funct3}.
  - Load/store/JAL/JALR/AUIPC/branch: ADD (0).
  - LUI: PASS_B (all ones).
- EXEC, operand select:
  - Asel = 1 for branch, JAL, AUIPC.
  - Bsel = 1 for every class except R-type.
- EXEC, branch resolution:
  - Taken condition: BEQ BrEq; BNE ~BrEq; BLT BrLT; BGE ~BrLT; BLTU BrLT with BrUn = 1; BGEU ~BrLT with BrUn = 1.
  - Taken: PCWEn = 1, PCSel = 1. Go to FETCH.
- EXEC, next state: load/store go to MEM; all other classes go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for stores. ALUSel/Bsel are held from EXEC.
  - On dmem_ready: load goes to WB, store goes to FETCH.
  - Timeout is handled as in FETCH.
- WB:
  - RegWEn = 1.
  - WBSel: 00 load, 10 JAL/JALR, 01 otherwise.
  - JAL/JALR additionally: PCWEn = 1, PCSel = 1. ALU ops are held from EXEC; for JALR the ALU result LSB is cleared by the datapath.
  - Go to FETCH.
- Latency (zero stall cycles): branch 3 cycles, ALU/LUI/AUIPC/JAL 4, store 4, load 5. Each stall cycle adds 1.
- Wait counter: cleared on every state change and on ready. MEM_WAIT_MAX stalled cycles trigger the trap; ready in the same cycle as the limit wins.
- TRAP: all enables 0, no requests. Held until rst; illegal and mem_timeout remain set.
- rst mid-instruction: the next cycle is FETCH with all outputs 0 and no partial write.

Test Plan:
- ADD (0x33, f3 000, f7_5 0), imem_ready high: states 0,1,2,4,0; ALUSel 0000; RegWEn = 1 only in WB, WBSel = 01.
- SUB (f7_5 = 1) and SRAI (0x13, f3 101, f7_5 1): ALUSel 1000 and 1101. ADDI with IR[30] = 1: ALUSel 0000.
- BGEU (0x63, f3 111) with BrLT = 0: BrUn = 1, PCWEn = PCSel = 1 in EXEC, back to FETCH in 3 cycles. Same with BrLT = 1: PCWEn only in FETCH.
- LW with dmem_ready low for 3 cycles: MEM lasts 4 cycles, then WB with WBSel 00; total 8 cycles. SW: dmem_we = 1, no RegWEn.
- imem_ready held low: mem_timeout = 1 after 15 stalled cycles, state 5. Pulse rst: state 0, flags 0.
- Opcode 0x7F: illegal = 1, state 5 after DECODE. JAL: WB asserts RegWEn, WBSel 10, PCWEn, PCSel.
